axis_load_merge: RTL
====================

# axis_load_merge

Collects packets from `IN_NUM_PORTS` parallel AXI4-Stream inputs and re-serializes them onto one output in strict round-robin packet order: port 0, port 1, …, port N-1, port 0, …. It also packs narrow input words into a wider output word. It sits directly downstream of the parallel processing instances fed by the load splitter, restoring the original packet order and the original data width. A port whose packet is late stalls the merge; packets are never reordered.

## Interface
- `IN_DATA_W`, 32: TDATA width of each input port.
- `OUT_DATA_W`, 64: TDATA width of the output. Must be ≥ `IN_DATA_W` and an integer multiple of it; elaboration `$error` otherwise. K = `OUT_DATA_W/IN_DATA_W`.
- `IN_NUM_PORTS`, 2: number of input streams, ≥ 1.
- `USER_W`, 1: TUSER width on all ports.
- `clk`  in  1: the single clock for the block.
- `rst`  in  1: reset, asynchronous and active-high.
- `i_tdata`  in  `[IN_DATA_W-1:0] [IN_NUM_PORTS]`: input data.
- `i_tuser`  in  `[USER_W-1:0] [IN_NUM_PORTS]`: input sideband.
- `i_tlast`  in  `1 [IN_NUM_PORTS]`: end of packet.
- `i_tvalid`  in  `1 [IN_NUM_PORTS]`: input valid.
- `i_tready`  out  `1 [IN_NUM_PORTS]`: input ready.
- `o_tdata`  out  `OUT_DATA_W`: packed output data.
- `o_tkeep`  out  `K`: one bit per `IN_DATA_W` sub-word, set when that sub-word is valid.
- `o_tuser`  out  `USER_W`: sideband for the output word.
- `o_tlast`  out  1: end of packet.
- `o_tvalid`  out  1: output valid.
- `o_tready`  in  1: output ready.

## Operation
- **Port selection.** `st_port` (width `$clog2(IN_NUM_PORTS)`, minimum 1) selects the active input.
  - Only `i_tready[st_port]` may be 1; every other `i_tready` is 0.
  - Inputs on non-selected ports are ignored.
  - `st_port` advances by 1 on acceptance of a beat with `i_tlast=1`. It wraps from `IN_NUM_PORTS-1` to 0.
  - With `IN_NUM_PORTS=1` it stays at 0.
- **Output register.** One output register holds the completed word: `o_tdata`, `o_tkeep`, `o_tuser`, `o_tlast` and `o_tvalid`.
- **Packing.**
  - Sub-word counter `cnt` runs 0..K-1.
  - An accepted beat is written to lane `cnt`, bits `[cnt*IN_DATA_W +: IN_DATA_W]`. The first sub-word goes in the LSBs.
  - An accepted beat completes the word when `cnt==K-1` or `i_tlast=1`. On completion:
    - the packed word is loaded into the output register;
    - `o_tkeep` is set to ones for lanes 0..cnt;
    - unused lanes are zero;
    - `o_tlast` = `i_tlast`;
    - `cnt` returns to 0.
  - Otherwise `cnt` increments.
  - `o_tuser` is the `i_tuser` of the word's first sub-word (lane 0).
- **Ready.** `i_tready[st_port] = !rst && (!o_tvalid || o_tready)`.
  - The rule is the same for non-completing beats; lane storage is a separate pack buffer.
  - The output register accepts a new word in the same cycle the old one leaves.
- **K=1.** The block degenerates to an ordered round-robin merge with a registered output, and `o_tkeep` is constantly 1 when valid.
- **Output holding.** While `o_tvalid=1` and `o_tready=0`, all output signals stay stable.

## Timing
- **Reset values.** While `rst` is asserted, asynchronously:
  - `o_tvalid=0`, `o_tlast=0`, `o_tdata=0`, `o_tkeep=0`, `o_tuser=0`;
  - `st_port=0`, `cnt=0`, pack buffer 0;
  - all `i_tready=0`.
- **After reset.** On the first cycle after deassertion, `i_tready[0]=1`.
- **Latency.** A completing beat accepted at edge n gives `o_tvalid=1` after edge n.
- **Throughput.** One input beat per cycle while `o_tready=1`. Output rate is one word per K input beats.
- **Simultaneous events.** Output drain and completing input in the same cycle: the new word replaces the old one and `o_tvalid` stays 1.
- **Port advance.** A `tlast` beat with `cnt==K-1` advances `st_port` and resets `cnt` in the same edge. The next cycle's ready is on the new port.
- **Short packet.** A 1-beat packet produces one output word with `o_tkeep` = 0…01 and `o_tlast=1`.
- **Reset mid-packet.** A partial word and the held output are discarded, and selection restarts at port 0.
- **Lost valid.** Deassertion of `i_tvalid` mid-word leaves `cnt` and the pack buffer unchanged; the block waits.

## Test plan
- **Basic pack.** K=2, N=2. Port 0 sends 4 beats A0..A3 with tlast on A3; port 1 sends B0..B1 with tlast on B1; `o_tready=1`. Required: output words {A1,A0}, {A3,A2,last}, {B1,B0,last}, all `o_tkeep`=11. `i_tready[1]` is 0 until the cycle after A3 is accepted.
- **Ordering stall.** Port 1 valid first with 2 beats; port 0 idle for 10 cycles, then sends 2 beats. Required: no port-1 beat accepted before port 0's tlast, and output order is port 0 then port 1.
- **Partial word.** K=4, 5-beat packet D0..D4. Required: word 1 is {D3..D0} with `o_tkeep`=1111 and `o_tlast=0`; word 2 is {0,0,0,D4} with `o_tkeep`=0001 and `o_tlast=1`.
- **Backpressure.** K=1, N=3. Random `o_tready` at 50%, 100 packets of random length 1–8. Required:
  - output matches a reference model in the sequence p0,p1,p2,p0…;
  - `o_*` stable while stalled;
  - `o_tuser` equals the lane-0 input tuser;
  - full rate with `o_tready` held at 1.
- **Asynchronous reset.** Assert `rst` between clock edges in the middle of a word, with `o_tvalid=1`. Required: `o_tvalid` and all `i_tready` go low immediately, without waiting for a clock edge. After release, port 0 is selected, `cnt=0`, and a fresh packet is output uncorrupted.
- **Elaboration checks.** Set `OUT_DATA_W=48` with `IN_DATA_W=32`, then `OUT_DATA_W=16` with `IN_DATA_W=32`. Required: elaboration `$error` in both cases.

Source files
------------

// File: rtl/axis_load_merge.sv
// axis_load_merge: ordered round-robin merge of IN_NUM_PORTS AXI4-Stream
// inputs onto one output. Narrow input beats are packed LSB-first into a
// wider output word. Packets are taken strictly as port 0, 1, ..., N-1, 0, ...
module axis_load_merge #(
    parameter int IN_DATA_W    = 32,
    parameter int OUT_DATA_W   = 64,
    parameter int IN_NUM_PORTS = 2,
    parameter int USER_W       = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [IN_DATA_W-1:0]              i_tdata  [IN_NUM_PORTS],
    input  logic [USER_W-1:0]                 i_tuser  [IN_NUM_PORTS],
    input  logic                              i_tlast  [IN_NUM_PORTS],
    input  logic                              i_tvalid [IN_NUM_PORTS],
    output logic                              i_tready [IN_NUM_PORTS],
    output logic [OUT_DATA_W-1:0]             o_tdata,
    output logic [OUT_DATA_W/IN_DATA_W-1:0]   o_tkeep,
    output logic [USER_W-1:0]                 o_tuser,
    output logic                              o_tlast,
    output logic                              o_tvalid,
    input  logic                              o_tready
);

    localparam int K      = OUT_DATA_W / IN_DATA_W;
    localparam int CNT_W  = (K > 1) ? $clog2(K) : 1;
    localparam int PORT_W = (IN_NUM_PORTS > 1) ? $clog2(IN_NUM_PORTS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(K - 1);
    localparam logic [PORT_W-1:0] PORT_LAST = PORT_W'(IN_NUM_PORTS - 1);

    // Parameter sanity: the output must hold a whole number of input lanes.
    if (OUT_DATA_W < IN_DATA_W || (OUT_DATA_W % IN_DATA_W) != 0) begin : g_bad_width
        $error("axis_load_merge: OUT_DATA_W (%0d) must be a multiple of IN_DATA_W (%0d)",
               OUT_DATA_W, IN_DATA_W);
    end
    if (IN_NUM_PORTS < 1) begin : g_bad_ports
        $error("axis_load_merge: IN_NUM_PORTS must be at least 1");
    end

    logic [PORT_W-1:0]     st_port;
    logic [CNT_W-1:0]      cnt;
    logic [OUT_DATA_W-1:0] pack_data;
    logic [USER_W-1:0]     pack_user;

    logic [IN_DATA_W-1:0]  sel_data;
    logic [USER_W-1:0]     sel_user;
    logic                  sel_last;
    logic                  sel_valid;

    logic                  take;
    logic                  accept;
    logic                  complete;

    logic [OUT_DATA_W-1:0] word_data;
    logic [K-1:0]          word_keep;
    logic [USER_W-1:0]     word_user;

    // The output register can take a new word when empty or draining this cycle.
    assign take     = !o_tvalid || o_tready;
    assign accept   = sel_valid && take;
    assign complete = accept && ((cnt == CNT_LAST) || sel_last);

    // Mux the currently selected input port; all other ports are ignored.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        sel_data  = '0;
        sel_user  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int p = 0; p < IN_NUM_PORTS; p++) begin
            if (st_port == PORT_W'(p)) begin
                sel_data  = i_tdata[p];
                sel_user  = i_tuser[p];
                sel_last  = i_tlast[p];
                sel_valid = i_tvalid[p];
            end
        end
    end

    // Ready only on the selected port, forced low while reset is asserted.
    always_comb begin
        for (int p = 0; p < IN_NUM_PORTS; p++) begin
            i_tready[p] = !rst && take && (st_port == PORT_W'(p));
        end
    end

    // Word as it would look with the incoming beat dropped into lane cnt.
    always_comb begin
        word_data = pack_data;
        word_data[cnt*IN_DATA_W +: IN_DATA_W] = sel_data;
        word_user = (cnt == '0) ? sel_user : pack_user;
        for (int i = 0; i < K; i++) begin
            word_keep[i] = (CNT_W'(i) <= cnt);
        end
    end

    // Lane counter, pack buffer and port pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_port   <= '0;
            cnt       <= '0;
            // NOTE: the pack buffer is reset because lanes above cnt must read
            // as zero in a short final word; it is cleared again on completion.
            pack_data <= '0;
            pack_user <= '0;
        end else if (accept) begin
            if (complete) begin
                cnt       <= '0;
                pack_data <= '0;
                pack_user <= '0;
            end else begin
                // NOTE: non-blocking assignments keep every register update
                // based on pre-edge values, independent of statement order.
                cnt       <= cnt + CNT_W'(1);
                pack_data <= word_data;
                pack_user <= word_user;
            end
            if (sel_last) begin
                st_port <= (st_port == PORT_LAST) ? '0 : st_port + PORT_W'(1);
            end
        end
    end

    // Output register: load on completion, otherwise clear valid once drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
            o_tdata  <= '0;
            o_tkeep  <= '0;
            o_tuser  <= '0;
        end else if (complete) begin
            o_tvalid <= 1'b1;
            o_tlast  <= sel_last;
            o_tdata  <= word_data;
            o_tkeep  <= word_keep;
            o_tuser  <= word_user;
        end else if (o_tready) begin
            o_tvalid <= 1'b0;
        end
    end

endmodule
